// File: rtl/ajit_accelerator_regfile.sv
`default_nettype none
// ============================================================================
// Module      : ajit_accelerator_regfile
// Description : AFB register-file accelerator slave for the AJIT core.
//               Accepts 74-bit AFB requests and performs byte-masked register
//               writes or register reads, with address range and alignment
//               checking. Returns a 33-bit {error, data} response. Raises
//               ACCELERATOR_INTERRUPT through a CONTROL/DOORBELL pair. The ACB
//               memory ports are present for drop-in compatibility and held
//               idle.
//
// Parameters  : NUM_REGS  - number of 32-bit registers (power of two, 4..64)
//               BASE_ADDR - block base address, aligned to NUM_REGS*4
//
// Ports       : clk, reset                       - clock, sync active-high reset
//               AFB_ACCELERATOR_REQUEST_pipe_*   - request pipe (req/ack/74b data)
//                   data: [73] lock (ignored), [72] 1=read/0=write,
//                         [71:68] byte mask, [67:32] address, [31:0] wdata
//               AFB_ACCELERATOR_RESPONSE_pipe_*  - response pipe (req/ack/33b data)
//                   data: [32] error, [31:0] read data
//               ACB_ACCELERATOR_MEM_*            - memory ports, held idle
//               ACCELERATOR_INTERRUPT            - irq_enable & irq_pending
//
// Register map: 0          CONTROL  bit0 irq_enable (RW),
//                                   bit1 irq_pending (R, write-1-to-clear)
//               NUM_REGS-1 DOORBELL RW; any nonzero-mask write sets pending
//               others     plain RW
//
// Build option: AJIT_ACC_ACCESS_COUNTER_EN - when defined, reg 1 becomes a
//               read-only saturating count of response handshakes.
//
// Revision    : 1.0 - initial release
// ============================================================================
module ajit_accelerator_regfile #(
  parameter int          NUM_REGS  = 16,
  parameter logic [35:0] BASE_ADDR = 36'h0
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          AFB_ACCELERATOR_REQUEST_pipe_write_req,
  output logic          AFB_ACCELERATOR_REQUEST_pipe_write_ack,
  input  logic [73:0]   AFB_ACCELERATOR_REQUEST_pipe_write_data,

  output logic [32:0]   AFB_ACCELERATOR_RESPONSE_pipe_read_data,
  input  logic          AFB_ACCELERATOR_RESPONSE_pipe_read_req,
  output logic          AFB_ACCELERATOR_RESPONSE_pipe_read_ack,

  output logic [109:0]  ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data,
  input  logic          ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req,
  output logic          ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack,

  input  logic [64:0]   ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data,
  input  logic          ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req,
  output logic          ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack,

  output logic          ACCELERATOR_INTERRUPT
);

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] c_control_idx  = '0;
  localparam logic [ADDR_W-1:0] c_doorbell_idx = ADDR_W'(NUM_REGS - 1);
`ifdef AJIT_ACC_ACCESS_COUNTER_EN
  localparam logic [ADDR_W-1:0] c_counter_idx  = ADDR_W'(1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic [73:0]   r_req_word;
  logic [32:0]   r_resp_data;
  logic [31:0]   r_regs [NUM_REGS];
  logic          r_irq_enable;
  logic          r_irq_pending;
  logic          r_irq;

  logic          w_req_hs;
  logic          w_resp_hs;
  logic          w_is_read;
  logic [3:0]    w_mask;
  logic [35:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [ADDR_W-1:0] w_index;
  logic          w_addr_err;
  logic          w_exec;
  logic          w_do_write;
  logic          w_plain_write;
  logic [31:0]   w_rdata;
  logic          w_irq_enable_nxt;
  logic          w_irq_pending_nxt;

  // --------------------------------------------------------------------------
  // Handshakes and outputs
  // --------------------------------------------------------------------------
  // Request ack is gated by reset so it reads 0 throughout the reset window.
  assign AFB_ACCELERATOR_REQUEST_pipe_write_ack = (r_state == ST_IDLE) && !reset;
  assign AFB_ACCELERATOR_RESPONSE_pipe_read_ack = (r_state == ST_RESP);
  assign AFB_ACCELERATOR_RESPONSE_pipe_read_data = r_resp_data;
  assign ACCELERATOR_INTERRUPT = r_irq;

  assign ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data  = '0;
  assign ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack   = 1'b0;
  assign ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack = 1'b0;

  // Inputs this generation deliberately ignores.
  logic w_unused_ok;
  assign w_unused_ok = ^{r_req_word[73],
                         ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req,
                         ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data,
                         ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req};

  assign w_req_hs  = AFB_ACCELERATOR_REQUEST_pipe_write_req &&
                     AFB_ACCELERATOR_REQUEST_pipe_write_ack;
  assign w_resp_hs = AFB_ACCELERATOR_RESPONSE_pipe_read_req &&
                     AFB_ACCELERATOR_RESPONSE_pipe_read_ack;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_req_hs)  w_next_state = ST_EXEC;
      ST_EXEC:                w_next_state = ST_RESP;
      ST_RESP: if (w_resp_hs) w_next_state = ST_IDLE;
      default:                w_next_state = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latch and decode
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset)         r_req_word <= '0;
    else if (w_req_hs) r_req_word <= AFB_ACCELERATOR_REQUEST_pipe_write_data;
  end

  assign w_is_read  = r_req_word[72];
  assign w_mask     = r_req_word[71:68];
  assign w_addr     = r_req_word[67:32];
  assign w_wdata    = r_req_word[31:0];
  assign w_index    = w_addr[ADDR_W+1:2];
  assign w_addr_err = (w_addr[35:ADDR_W+2] != BASE_ADDR[35:ADDR_W+2]) ||
                      (w_addr[1:0] != 2'b00);
  assign w_exec     = (r_state == ST_EXEC);
  assign w_do_write = w_exec && !w_is_read && !w_addr_err;

  // CONTROL lives in dedicated flops and the counter (when built) shadows
  // reg 1, so neither is written through the array.
`ifdef AJIT_ACC_ACCESS_COUNTER_EN
  assign w_plain_write = w_do_write && (w_index != c_control_idx) &&
                         (w_index != c_counter_idx);
`else
  assign w_plain_write = w_do_write && (w_index != c_control_idx);
`endif

`ifdef AJIT_ACC_ACCESS_COUNTER_EN
  logic [31:0] r_access_count;

  // Counts every completed response, errors included; saturates at all-ones.
  always_ff @(posedge clk) begin
    if (reset)
      r_access_count <= '0;
    else if (w_resp_hs && (r_access_count != 32'hFFFF_FFFF))
      r_access_count <= r_access_count + 32'd1;
  end
`endif

  // Read mux uses current register values, i.e. before this EXEC's update.
  always_comb begin
    w_rdata = r_regs[w_index];
    if (w_index == c_control_idx)
      w_rdata = {30'd0, r_irq_pending, r_irq_enable};
`ifdef AJIT_ACC_ACCESS_COUNTER_EN
    else if (w_index == c_counter_idx)
      w_rdata = r_access_count;
`endif
  end

  // --------------------------------------------------------------------------
  // Register storage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_plain_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_mask[b]) r_regs[w_index][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Interrupt control. Pending clear (CONTROL) and set (DOORBELL) target
  // different indices, so they never collide in one EXEC cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_irq_enable_nxt  = r_irq_enable;
    w_irq_pending_nxt = r_irq_pending;
    if (w_do_write && (w_index == c_control_idx) && w_mask[0]) begin
      w_irq_enable_nxt = w_wdata[0];
      if (w_wdata[1]) w_irq_pending_nxt = 1'b0;
    end
    if (w_do_write && (w_index == c_doorbell_idx) && (w_mask != 4'h0))
      w_irq_pending_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_enable  <= 1'b0;
      r_irq_pending <= 1'b0;
      r_irq         <= 1'b0;
    end else begin
      r_irq_enable  <= w_irq_enable_nxt;
      r_irq_pending <= w_irq_pending_nxt;
      r_irq         <= w_irq_enable_nxt & w_irq_pending_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Response register, loaded in EXEC and held until the response handshake.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset)
      r_resp_data <= '0;
    else if (w_exec) begin
      if (w_addr_err)     r_resp_data <= {1'b1, 32'h0};
      else if (w_is_read) r_resp_data <= {1'b0, w_rdata};
      else                r_resp_data <= {1'b0, 32'h0};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ajit_accelerator_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_ajit_accelerator_regfile
// Description : Directed self-checking bench for ajit_accelerator_regfile
//               (NUM_REGS=16, BASE_ADDR=0). Honors AJIT_ACC_ACCESS_COUNTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ajit_accelerator_regfile;

  logic          clk;
  logic          reset;
  logic          req_v;
  logic          req_ack;
  logic [73:0]   req_data;
  logic [32:0]   resp_data;
  logic          resp_req;
  logic          resp_ack;
  logic [109:0]  acb_req_data;
  logic          acb_req_ack;
  logic          acb_resp_ack;
  logic          irq;

  int            errors = 0;
  int            checks = 0;
  logic [32:0]   r;
  logic [32:0]   held;
  int            lat;

  ajit_accelerator_regfile #(.NUM_REGS(16), .BASE_ADDR(36'h0)) dut (
    .clk                                          (clk),
    .reset                                        (reset),
    .AFB_ACCELERATOR_REQUEST_pipe_write_req       (req_v),
    .AFB_ACCELERATOR_REQUEST_pipe_write_ack       (req_ack),
    .AFB_ACCELERATOR_REQUEST_pipe_write_data      (req_data),
    .AFB_ACCELERATOR_RESPONSE_pipe_read_data      (resp_data),
    .AFB_ACCELERATOR_RESPONSE_pipe_read_req       (resp_req),
    .AFB_ACCELERATOR_RESPONSE_pipe_read_ack       (resp_ack),
    .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data   (acb_req_data),
    .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req    (1'b1),
    .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack    (acb_req_ack),
    .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data (65'h1_2345_6789_ABCD_EF01),
    .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req  (1'b1),
    .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack  (acb_resp_ack),
    .ACCELERATOR_INTERRUPT                        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request and complete its handshake.
  task automatic send_req(input logic rd, input logic [3:0] mask,
                          input logic [35:0] addr, input logic [31:0] data);
    int n;
    @(negedge clk);
    req_v    = 1'b1;
    req_data = {1'b0, rd, mask, addr, data};
    n = 0;
    while (req_ack !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $error("FAIL req_timeout observed=no_ack expected=ack");
    end
    @(posedge clk);
    #1;
    req_v = 1'b0;
  endtask

  // Collect the response; lat = edges from request handshake to response handshake.
  task automatic get_resp(output logic [32:0] d, output int l);
    int n;
    resp_req = 1'b1;
    l = 1;
    n = 0;
    d = 'x;
    forever begin
      @(negedge clk);
      if (resp_ack === 1'b1) break;
      l++;
      n++;
      if (n >= 50) break;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $error("FAIL resp_timeout observed=no_ack expected=ack");
    end
    d = resp_data;
    @(posedge clk);
    #1;
    resp_req = 1'b0;
  endtask

  task automatic xact(input logic rd, input logic [3:0] mask,
                      input logic [35:0] addr, input logic [31:0] data,
                      output logic [32:0] d);
    int l;
    send_req(rd, mask, addr, data);
    get_resp(d, l);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    req_v    = 1'b0;
    req_data = '0;
    resp_req = 1'b0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    chk("req_ack_in_reset", {32'd0, req_ack}, 33'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("req_ack_after_reset", {32'd0, req_ack}, 33'd1);
    chk("resp_ack_after_reset", {32'd0, resp_ack}, 33'd0);
    chk("resp_data_after_reset", resp_data, 33'd0);
    chk("irq_after_reset", {32'd0, irq}, 33'd0);
    chk("acb_outputs", {30'd0, |acb_req_data, acb_req_ack, acb_resp_ack}, 33'd0);

    // ---- full write / read with latency ----
    xact(1'b0, 4'hF, 36'h8, 32'hDEAD_BEEF, r);
    chk("wr_reg2_resp", r, 33'h0_0000_0000);
    send_req(1'b1, 4'hF, 36'h8, 32'h0);
    get_resp(r, lat);
    chk("rd_reg2", r, 33'h0_DEAD_BEEF);
    chk("rd_latency", 33'(lat), 33'd2);

    // ---- byte mask ----
    xact(1'b0, 4'b0101, 36'hC, 32'h1122_3344, r);
    chk("wr_reg3_mask_resp", r, 33'h0_0000_0000);
    xact(1'b1, 4'hF, 36'hC, 32'h0, r);
    chk("rd_reg3_masked", r, 33'h0_0022_0044);

    // ---- mask 0 is a no-op ----
    xact(1'b0, 4'h0, 36'h8, 32'h0BAD_F00D, r);
    chk("wr_mask0_resp", r, 33'h0_0000_0000);
    xact(1'b1, 4'hF, 36'h8, 32'h0, r);
    chk("rd_after_mask0", r, 33'h0_DEAD_BEEF);

    // ---- address errors ----
    xact(1'b0, 4'hF, 36'h48, 32'h1234_5678, r);
    chk("wr_out_of_range", r, 33'h1_0000_0000);
    xact(1'b0, 4'hF, 36'hA, 32'h1234_5678, r);
    chk("wr_misaligned", r, 33'h1_0000_0000);
    xact(1'b0, 4'hF, 36'h8_0000_0008, 32'h1234_5678, r);
    chk("wr_high_addr", r, 33'h1_0000_0000);
    xact(1'b1, 4'hF, 36'h100, 32'h0, r);
    chk("rd_out_of_range", r, 33'h1_0000_0000);
    xact(1'b1, 4'hF, 36'h8, 32'h0, r);
    chk("rd_reg2_after_errors", r, 33'h0_DEAD_BEEF);

    // ---- interrupt via CONTROL / DOORBELL ----
    xact(1'b0, 4'hF, 36'h0, 32'h1, r);
    chk("irq_enable_only", {32'd0, irq}, 33'd0);
    xact(1'b0, 4'hF, 36'h3C, 32'h5, r);
    chk("irq_after_doorbell", {32'd0, irq}, 33'd1);
    xact(1'b1, 4'hF, 36'h0, 32'h0, r);
    chk("rd_control_pending", r, 33'h0_0000_0003);
    xact(1'b1, 4'hF, 36'h3C, 32'h0, r);
    chk("rd_doorbell", r, 33'h0_0000_0005);
    xact(1'b0, 4'hF, 36'h0, 32'h3, r);
    chk("irq_after_clear", {32'd0, irq}, 33'd0);
    xact(1'b1, 4'hF, 36'h0, 32'h0, r);
    chk("rd_control_cleared", r, 33'h0_0000_0001);

`ifndef AJIT_ACC_ACCESS_COUNTER_EN
    // ---- reg 1 plain RW ----
    xact(1'b0, 4'hF, 36'h4, 32'hA5A5_A5A5, r);
    xact(1'b1, 4'hF, 36'h4, 32'h0, r);
    chk("rd_reg1_rw", r, 33'h0_A5A5_A5A5);
`endif

    // Re-arm the interrupt so the abort below has visible state to clear.
    xact(1'b0, 4'hF, 36'h3C, 32'h7, r);
    chk("irq_rearmed", {32'd0, irq}, 33'd1);

    // ---- stalled response, blocked second request, reset in RESP ----
    send_req(1'b1, 4'hF, 36'h3C, 32'h0);
    resp_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("stall_resp_ack", {32'd0, resp_ack}, 33'd1);
    held = resp_data;
    chk("stall_resp_value", held, 33'h0_0000_0007);
    req_v    = 1'b1;
    req_data = {1'b0, 1'b0, 4'hF, 36'h10, 32'hFFFF_FFFF};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_hold_data", resp_data, held);
      chk("stall_req_ack", {32'd0, req_ack}, 33'd0);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_resp_ack", {32'd0, resp_ack}, 33'd0);
    chk("reset_req_ack", {32'd0, req_ack}, 33'd0);
    chk("reset_irq", {32'd0, irq}, 33'd0);
    chk("reset_resp_data", resp_data, 33'd0);
    req_v = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      xact(1'b1, 4'hF, 36'(i * 4), 32'h0, r);
`ifdef AJIT_ACC_ACCESS_COUNTER_EN
      // reg 1 reports the completed-transaction count (only reg 0's read).
      chk("rd_after_reset", r, (i == 1) ? 33'h0_0000_0001 : 33'h0_0000_0000);
`else
      chk("rd_after_reset", r, 33'h0_0000_0000);
`endif
    end

`ifdef AJIT_ACC_ACCESS_COUNTER_EN
    // ---- transaction counter ----
    do_reset();
    xact(1'b0, 4'hF, 36'h10, 32'h1, r);
    xact(1'b1, 4'hF, 36'h10, 32'h0, r);
    xact(1'b0, 4'hF, 36'h200, 32'h0, r);
    xact(1'b1, 4'hF, 36'h4, 32'h0, r);
    chk("counter_after_3", r, 33'h0_0000_0003);
    xact(1'b0, 4'hF, 36'h4, 32'hA5A5_A5A5, r);
    chk("counter_write_resp", r, 33'h0_0000_0000);
    xact(1'b1, 4'hF, 36'h4, 32'h0, r);
    chk("counter_after_5", r, 33'h0_0000_0005);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
